// File: rtl/det_ctrl.sv
// Serial pattern detector: counts overlapping matches of a 1..8-bit pattern and flags when a threshold is hit.
// Match pulse and counters register one cycle after the accepting edge; bit_ready is high only while running.
module det_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [7:0] cfg_pattern,
    input  logic [3:0] cfg_len,
    input  logic [7:0] cfg_thresh,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       bit_ready,
    output logic       match,
    output logic [7:0] match_cnt,
    output logic       irq,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] pattern;
        logic [3:0] len;
        logic [7:0] thresh;
    } cfg_t;

    localparam cfg_t CFG_RST = '{pattern: 8'h0B, len: 4'd4, thresh: 8'd0};

    state_t     state_q, state_d;
    cfg_t       cfg_q, cfg_d;
    // Bit 7 of the history is shifted out before it can ever be compared, so only 7 bits are kept.
    logic [6:0] hist_q, hist_d;
    logic [3:0] fill_q, fill_d;
    logic [7:0] cnt_q, cnt_d;
    logic       irq_q, irq_d;
    logic       match_q, match_d;

    logic       len_ok;
    logic       go;
    logic [7:0] mask;
    logic [7:0] hist_sh;
    logic [3:0] fill_inc;
    logic [7:0] cnt_inc;
    logic       hit;

    assign len_ok   = (cfg_q.len != 4'd0) && (cfg_q.len <= 4'd8);
    assign go       = start && !stop;
    assign mask     = ~(8'hFF << cfg_q.len);
    assign hist_sh  = {hist_q, bit_in};
    assign fill_inc = (fill_q >= cfg_q.len) ? cfg_q.len : fill_q + 4'd1;
    assign cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign hit      = (fill_inc == cfg_q.len) && (((hist_sh ^ cfg_q.pattern) & mask) == 8'h00);

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        irq_d   = irq_q;
        match_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    cfg_d = '{pattern: cfg_pattern, len: cfg_len, thresh: cfg_thresh};
                end
                if (go && len_ok) begin
                    state_d = RUN;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                    irq_d   = 1'b0;
                end
            end
            RUN: begin
                // A bit arriving with stop is dropped so an aborted run never reports a late match.
                if (stop) begin
                    state_d = IDLE;
                end else if (bit_valid) begin
                    hist_d = hist_sh[6:0];
                    fill_d = fill_inc;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        if (!clr && (cfg_q.thresh != 8'd0) && (cnt_inc == cfg_q.thresh)) begin
                            irq_d   = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (go) begin
                    state_d = RUN;
                    hist_d  = '0;
                    fill_d  = '0;
                    cnt_d   = '0;
                    irq_d   = 1'b0;
                end else if (clr) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr) begin
            cnt_d = '0;
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cfg_q   <= CFG_RST;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            match_q <= match_d;
        end
    end

    assign bit_ready = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign irq       = irq_q;

endmodule
